fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 14 +
 rtl/fetch_unit_sat_counter16.sv | 29 ++
 rtl/fetch_unit.sv | 106 ++++++++++
 tb/tb_fetch_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

  localparam int unsigned PC_W    = 10;
  localparam int unsigned INSTR_W = 32;

  localparam logic [PC_W-1:0] PC_INC = 10'd4;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_sat_counter16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [15:0] count
);

  logic [15:0] count_q;
  logic [15:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, RUN/HALT FSM
// and fetch/bubble statistics counters.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [PC_W-1:0]    HALT_PC  = 10'h104,
  parameter logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_target,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc,
  output logic [PC_W-1:0]    ifid_pc_plus4,
  output logic               ifid_valid,
  output logic               halted,
  output logic [15:0]        fetch_cnt,
  output logic [15:0]        bubble_cnt
);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    ifid_pc_q, ifid_pc_d;
  logic [PC_W-1:0]    ifid_pc_plus4_q, ifid_pc_plus4_d;
  logic               valid_q, valid_d;
  logic               fetch_inc;
  logic               bubble_inc;

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    instr_d         = instr_q;
    ifid_pc_d       = ifid_pc_q;
    ifid_pc_plus4_d = ifid_pc_plus4_q;
    valid_d         = valid_q;
    fetch_inc       = 1'b0;
    bubble_inc      = (state_q == RUN) && (stall || redirect_valid);

    // Redirect wins over everything, including a stall and the HALT state.
    if (redirect_valid) begin
      state_d = RUN;
      pc_d    = {redirect_target[PC_W-1:2], 2'b00};
      valid_d = 1'b0;
      instr_d = NOP_WORD;
    end else if (state_q == HALT) begin
      valid_d = 1'b0;
      instr_d = NOP_WORD;
    end else if (pc_q == HALT_PC) begin
      state_d = HALT;
      valid_d = 1'b0;
      instr_d = NOP_WORD;
    end else if (!stall) begin
      pc_d            = pc_q + PC_INC;
      instr_d         = imem_data;
      ifid_pc_d       = pc_q;
      ifid_pc_plus4_d = pc_q + PC_INC;
      valid_d         = 1'b1;
      fetch_inc       = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= RUN;
      pc_q            <= '0;
      instr_q         <= NOP_WORD;
      ifid_pc_q       <= '0;
      ifid_pc_plus4_q <= '0;
      valid_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      instr_q         <= instr_d;
      ifid_pc_q       <= ifid_pc_d;
      ifid_pc_plus4_q <= ifid_pc_plus4_d;
      valid_q         <= valid_d;
    end
  end

  sat_counter16 u_fetch_cnt (
    .clk   (clk),
    .rst   (reset),
    .inc   (fetch_inc),
    .count (fetch_cnt)
  );

  sat_counter16 u_bubble_cnt (
    .clk   (clk),
    .rst   (reset),
    .inc   (bubble_inc),
    .count (bubble_cnt)
  );

  assign imem_addr     = pc_q;
  assign ifid_instr    = instr_q;
  assign ifid_pc       = ifid_pc_q;
  assign ifid_pc_plus4 = ifid_pc_plus4_q;
  assign ifid_valid    = valid_q;
  assign halted        = (state_q == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// stall/redirect traffic against a behavioural fetch model.
module tb_fetch_unit;

  localparam logic [9:0]  HALT_PC  = 10'h104;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [9:0]  redirect_target;
  logic [9:0]  imem_addr;
  logic [31:0] imem_data;
  logic [31:0] ifid_instr;
  logic [9:0]  ifid_pc;
  logic [9:0]  ifid_pc_plus4;
  logic        ifid_valid;
  logic        halted;
  logic [15:0] fetch_cnt;
  logic [15:0] bubble_cnt;

  logic [31:0] mem [256];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state, kept as plain integers.
  int          m_pc, m_ipc, m_ip4, m_fc, m_bc;
  logic [31:0] m_instr;
  bit          m_valid, m_halt;

  fetch_unit #(
    .HALT_PC  (HALT_PC),
    .NOP_WORD (NOP_WORD)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .ifid_instr      (ifid_instr),
    .ifid_pc         (ifid_pc),
    .ifid_pc_plus4   (ifid_pc_plus4),
    .ifid_valid      (ifid_valid),
    .halted          (halted),
    .fetch_cnt       (fetch_cnt),
    .bubble_cnt      (bubble_cnt)
  );

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr[9:2]];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
  endtask

  function automatic int sat_inc(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic model_reset();
    m_pc = 0; m_ipc = 0; m_ip4 = 0; m_fc = 0; m_bc = 0;
    m_instr = NOP_WORD; m_valid = 0; m_halt = 0;
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".imem_addr"}, 32'(imem_addr), 32'(m_pc));
    check_eq({tag, ".instr"},     ifid_instr,     m_instr);
    check_eq({tag, ".ifid_pc"},   32'(ifid_pc),   32'(m_ipc));
    check_eq({tag, ".pc_plus4"},  32'(ifid_pc_plus4), 32'(m_ip4));
    check_eq({tag, ".valid"},     32'(ifid_valid), 32'(m_valid));
    check_eq({tag, ".halted"},    32'(halted),    32'(m_halt));
    check_eq({tag, ".fetch_cnt"}, 32'(fetch_cnt), 32'(m_fc));
    check_eq({tag, ".bubble_cnt"},32'(bubble_cnt),32'(m_bc));
  endtask

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic cycle(input bit st, input bit rv, input logic [9:0] tgt, input string tag);
    stall = st; redirect_valid = rv; redirect_target = tgt;
    if (rv) begin
      if (!m_halt) m_bc = sat_inc(m_bc);
      m_pc = (int'(tgt) / 4) * 4;
      m_valid = 0; m_instr = NOP_WORD; m_halt = 0;
    end else if (m_halt) begin
      m_valid = 0; m_instr = NOP_WORD;
    end else if (m_pc == int'(HALT_PC)) begin
      if (st) m_bc = sat_inc(m_bc);
      m_halt = 1; m_valid = 0; m_instr = NOP_WORD;
    end else if (st) begin
      m_bc = sat_inc(m_bc);
    end else begin
      m_instr = mem[m_pc / 4];
      m_ipc = m_pc;
      m_ip4 = (m_pc + 4) % 1024;
      m_valid = 1;
      m_pc = (m_pc + 4) % 1024;
      m_fc = sat_inc(m_fc);
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, ".imem_addr"}, 32'(imem_addr), 32'h0);
    check_eq({tag, ".instr"},     ifid_instr, NOP_WORD);
    check_eq({tag, ".ifid_pc"},   32'(ifid_pc), 32'h0);
    check_eq({tag, ".pc_plus4"},  32'(ifid_pc_plus4), 32'h0);
    check_eq({tag, ".valid"},     32'(ifid_valid), 32'h0);
    check_eq({tag, ".halted"},    32'(halted), 32'h0);
    check_eq({tag, ".fetch_cnt"}, 32'(fetch_cnt), 32'h0);
    check_eq({tag, ".bubble_cnt"},32'(bubble_cnt), 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1; stall = 0; redirect_valid = 0; redirect_target = '0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    check_reset_values("reset");
    reset = 1'b0;
  endtask

  initial begin
    int          bc0;
    int          budget;
    logic [9:0]  tgt;

    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h8C01_0000;
    reset = 1'b1; stall = 0; redirect_valid = 0; redirect_target = '0;
    #2;
    check_reset_values("async_reset_t0");

    // Sequential fetch from address 0.
    do_reset();
    cycle(0, 0, '0, "first_fetch");
    check_eq("first_instr", ifid_instr, 32'h8C01_0000);
    check_eq("first_addr", 32'(imem_addr), 32'h4);

    // Load-use stall at 0x0BC.
    while (m_pc != 'hBC) cycle(0, 0, '0, "seq");
    bc0 = int'(bubble_cnt);
    cycle(1, 0, '0, "stall");
    check_eq("stall_pc_hold", 32'(imem_addr), 32'h0BC);
    check_eq("stall_bubble", 32'(bubble_cnt), 32'(bc0 + 1));
    cycle(0, 0, '0, "resume");
    check_eq("resume_pc", 32'(ifid_pc), 32'h0BC);

    // Redirect with a simultaneous stall, then a misaligned target.
    cycle(1, 1, 10'h0E0, "redir_stall");
    check_eq("redir_pc", 32'(imem_addr), 32'h0E0);
    check_eq("redir_flush", 32'(ifid_valid), 32'h0);
    cycle(0, 0, '0, "after_redir");
    check_eq("after_redir_pc", 32'(ifid_pc), 32'h0E0);
    cycle(0, 1, 10'h103, "misaligned");
    check_eq("misaligned_pc", 32'(imem_addr), 32'h100);

    // Run from reset to HALT, then wrap via a redirect to 0x3FC.
    do_reset();
    budget = 0;
    while (!halted && budget < 200) begin
      cycle(0, 0, '0, "to_halt");
      budget++;
    end
    check_eq("halt_reached", 32'(halted), 32'h1);
    check_eq("halt_valid", 32'(ifid_valid), 32'h0);
    check_eq("halt_fetch_cnt", 32'(fetch_cnt), 32'd65);
    cycle(1, 0, '0, "halt_hold");
    cycle(0, 0, '0, "halt_hold");
    check_eq("halt_no_bubble", 32'(bubble_cnt), 32'h0);
    cycle(0, 1, 10'h3FC, "redir_wrap");
    check_eq("wrap_unhalt", 32'(halted), 32'h0);
    cycle(0, 0, '0, "wrap0");
    check_eq("wrap_pc_3fc", 32'(ifid_pc), 32'h3FC);
    check_eq("wrap_plus4", 32'(ifid_pc_plus4), 32'h000);
    cycle(0, 0, '0, "wrap1");
    check_eq("wrap_pc_000", 32'(ifid_pc), 32'h000);

    // Asynchronous reset between edges at pc 0x050, with stall/redirect asserted.
    do_reset();
    while (m_pc != 'h50) cycle(0, 0, '0, "to_50");
    stall = 1; redirect_valid = 1; redirect_target = 10'h2A0;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_reset_values("async_reset_mid");
    @(negedge clk);
    reset = 1'b0;
    cycle(0, 0, '0, "post_async");
    check_eq("post_async_pc", 32'(ifid_pc), 32'h0);

    // Randomized traffic; targets biased near HALT_PC so HALT is exercised.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 1) == 0) tgt = 10'($urandom_range(32'h0E0, 32'h107));
      else tgt = 10'($urandom_range(0, 1023));
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, tgt, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
